// File: rtl/mpy_seq_ctrl.sv
// mpy_seq_ctrl -- iterative 32x32 shift-add multiply controller.
//
// One multiply takes 32 RUN iterations plus a FIX step that applies the sign
// and registers the product into Y_hi/Y_lo together with the N/Z flags.
// busy is high while the engine is in RUN or FIX so the control unit can stall;
// done pulses for one cycle when the result is valid.
//
// Optional feature (compile-time macro MPY_EARLY_EXIT_EN):
//   when defined, RUN exits to FIX as soon as the remaining multiplier bits
//   are all zero, so latency depends on the highest set bit of |T|.
//   When undefined, every multiply runs the full WIDTH iterations.

module mpy_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6    // must satisfy 2**CNT_W > WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y_hi,
    output logic [WIDTH-1:0] Y_lo,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int              PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PW-1:0]     acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  y_hi_q;
    logic [WIDTH-1:0]  y_lo_q;
    logic              n_q;
    logic              z_q;

    logic [WIDTH-1:0]  s_mag_d;
    logic [WIDTH-1:0]  t_mag_d;
    logic              neg_d;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     prod_d;
    logic              last_iter;
    logic              early_exit;

    // Operand magnitudes and result sign; the most negative value negates to
    // itself, which is exactly its unsigned magnitude, so no special case.
    always_comb begin
        s_mag_d = (signed_op && S[WIDTH-1]) ? (-S) : S;
        t_mag_d = (signed_op && T[WIDTH-1]) ? (-T) : T;
        neg_d   = signed_op & (S[WIDTH-1] ^ T[WIDTH-1]);
    end

    // One shift-add step and the final sign-corrected product.
    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        prod_d    = neg_q ? (-acc_q) : acc_q;
        last_iter = (cnt_q == LAST_CNT);
`ifdef MPY_EARLY_EXIT_EN
        early_exit = (mplier_q == '0);
`else
        early_exit = 1'b0;
`endif
    end

    // Control FSM with registered outputs; reset discards any in-flight multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_hi_q   <= '0;
            y_lo_q   <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, s_mag_d};
                        mplier_q <= t_mag_d;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (early_exit) begin
                        // Remaining multiplier bits are zero: nothing left to add.
                        state_q <= FIX;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    y_hi_q  <= prod_d[PW-1:WIDTH];
                    y_lo_q  <= prod_d[WIDTH-1:0];
                    n_q     <= prod_d[PW-1];
                    z_q     <= (prod_d == '0);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // start is deliberately ignored here; it is not queued.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Y_hi = y_hi_q;
    assign Y_lo = y_lo_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign C    = 1'b0;
    assign V    = 1'b0;

endmodule

// File: tb/tb_mpy_seq_ctrl.sv
// Directed bench for mpy_seq_ctrl: latency, busy window, done pulse width,
// product values and flags, ignored start while busy, and mid-run reset.
// Build with MPY_EARLY_EXIT_EN defined to check the early-exit latencies.

module tb_mpy_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic [31:0] Y_hi;
    logic [31:0] Y_lo;
    logic        C;
    logic        V;
    logic        N;
    logic        Z;

    int tests = 0;
    int fails = 0;

    mpy_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .S(S), .T(T), .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo),
        .C(C), .V(V), .N(N), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected cycles from the start edge to the done cycle. With early exit,
    // RUN stops once the shifted multiplier is zero, but never runs more than
    // 32 iterations, so a multiplier with bit 31 set still takes 33.
    function automatic int exp_lat(input logic sgn, input logic [31:0] t);
        logic [31:0] m;
        int          hb;
        m  = (sgn && t[31]) ? (-t) : t;
        hb = -1;
        for (int i = 0; i < 32; i++) if (m[i]) hb = i;
`ifdef MPY_EARLY_EXIT_EN
        if (hb < 0) return 2;
        return (hb + 3 > 33) ? 33 : hb + 3;
`else
        return (hb > 99) ? 0 : 33;
`endif
    endfunction

    // Present operands for one edge, then scramble them: the DUT must not care.
    task automatic go(input logic sgn, input logic [31:0] s, input logic [31:0] t);
        signed_op = sgn;
        S = s;
        T = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        S = $urandom;
        T = $urandom;
        signed_op = $urandom_range(0, 1);
    endtask

    // Called 1 time unit after the start edge; follows the run to done.
    task automatic wait_result(input string tag, input int lat, input logic [63:0] y,
                               input logic en, input logic ez);
        int n;
        int bcnt;
        logic got;
        n = 0;
        got = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        chk({tag, " done_seen"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, " Y"}, {Y_hi, Y_lo}, y);
        chk({tag, " N"}, 64'(N), 64'(en));
        chk({tag, " Z"}, 64'(Z), 64'(ez));
        @(posedge clk);
        #1;
        chk({tag, " done_1cyc"}, 64'(done), 64'd0);
        chk({tag, " Y_held"}, {Y_hi, Y_lo}, y);
    endtask

    initial begin
        int dcnt;
        int bcnt;
        logic got;

        reset = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        S = '0;
        T = '0;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset Y", {Y_hi, Y_lo}, 64'd0);
        chk("reset NZCV", {60'd0, N, Z, C, V}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        go(1'b0, 32'd7, 32'd6);
        wait_result("u7x6", exp_lat(1'b0, 32'd6), 64'h0000_0000_0000_002A, 1'b0, 1'b0);

        go(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("uFFxFF", exp_lat(1'b0, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);

        go(1'b0, 32'h8000_0000, 32'd2);
        wait_result("u8000x2", exp_lat(1'b0, 32'd2), 64'h0000_0001_0000_0000, 1'b0, 1'b0);

        go(1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_result("s-3x5", exp_lat(1'b1, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0);

        go(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_result("sMINxMIN", exp_lat(1'b1, 32'h8000_0000), 64'h4000_0000_0000_0000, 1'b0, 1'b0);

        go(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("s-1x-1", exp_lat(1'b1, 32'hFFFF_FFFF), 64'h0000_0000_0000_0001, 1'b0, 1'b0);

        // Zero multiplier: product 0 with a negative-sign request must not set N.
        go(1'b1, 32'hDEAD_BEEF, 32'd0);
        wait_result("s0xDEADBEEF", exp_lat(1'b1, 32'd0), 64'd0, 1'b0, 1'b1);

        // start held high with new operands while running: second request waits.
        signed_op = 1'b0;
        S = 32'd7;
        T = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        S = 32'd100;
        T = 32'd200;
        wait_result("held_first", exp_lat(1'b0, 32'd6), 64'd42, 1'b0, 1'b0);
        // The first IDLE edge after done picks up the still-asserted start.
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("held second_accept", 64'(got), 64'd1);
        wait_result("held_second", exp_lat(1'b0, 32'd200), 64'd20000, 1'b0, 1'b0);

        // Reset mid-multiply clears everything at once and suppresses done.
        go(1'b0, 32'h0001_2345, 32'h0000_0777);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst Y", {Y_hi, Y_lo}, 64'd0);
        chk("midrst NZ", {62'd0, N, Z}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("midrst no_done", 64'(dcnt), 64'd0);
        chk("midrst idle", 64'(bcnt), 64'd0);
        go(1'b0, 32'd2, 32'd3);
        wait_result("post_rst 2x3", exp_lat(1'b0, 32'd3), 64'd6, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
